// File: rtl/set_cmd_sched.sv
// set_cmd_sched
// Queues set-operation commands in a small FIFO and issues them one at a
// time to a set-counting engine, then presents the engine result together
// with the tag of the command that produced it.
//
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   cmd_*          command input (valid/ready), 3 centres, 3 radii, mode
//   set_en         one-cycle start pulse to the engine
//   set_central/radius/mode  head command held for the engine
//   set_busy       engine busy; no issue while high
//   set_valid      engine done strobe, set_candidate its count
//   res_*          result output (valid/ready), count, tag, timeout flag
//
// Configuration
//   SET_SCHED_TIMEOUT_EN  when defined, WAIT gives up after TIMEOUT cycles
//                         and returns res_err=1, res_candidate=0.
module set_cmd_sched #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  input  logic [23:0] cmd_central,
  input  logic [11:0] cmd_radius,
  input  logic [1:0]  cmd_mode,
  output logic        cmd_ready,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_candidate,
  output logic [3:0]  res_tag,
  output logic        res_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 42;  // {tag[4], mode[2], radius[12], central[24]}
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  // Elaboration-time guard against unsupported parameter values.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      TIMEOUT < 1 || TIMEOUT > 1023) begin : g_param_check
    $error("set_cmd_sched: unsupported FIFO_DEPTH or TIMEOUT");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

  state_t        state_reg;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg, count_next;
  logic [3:0]    tag_reg;
  logic          cmd_ready_reg;
  logic          push, pop, to_hit;
  logic [EW-1:0] head;

  assign cmd_ready = cmd_ready_reg;
  assign push      = cmd_valid & cmd_ready_reg;
  // Shallow register file: the head is read directly so it can be copied
  // to set_* on the same edge that enters ISSUE.
  assign head      = fifo_mem[rd_ptr_reg];

`ifdef SET_SCHED_TIMEOUT_EN
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);
  logic [9:0] to_cnt_reg;
  logic       res_err_reg;
  // Counter holds the number of WAIT cycles already elapsed, so the
  // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1.
  assign to_hit  = (state_reg == WAIT) && (to_cnt_reg == TO_LAST);
  assign res_err = res_err_reg;
`else
  assign to_hit  = 1'b0;
  assign res_err = 1'b0;
`endif

  assign pop = (state_reg == WAIT) && (set_valid || to_hit);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + (AW+1)'(1);
      2'b01:   count_next = count_reg - (AW+1)'(1);
      default: count_next = count_reg;
    endcase
  end

  // Storage carries no reset; occupancy is tracked by count_reg alone.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {tag_reg, cmd_mode, cmd_radius, cmd_central};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      tag_reg       <= '0;
      cmd_ready_reg <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
        tag_reg    <= tag_reg + 4'd1;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg     <= count_next;
      // Derived from next occupancy so cmd_ready is a pure register output.
      cmd_ready_reg <= (count_next != FULL_CNT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      set_en        <= 1'b0;
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
`ifdef SET_SCHED_TIMEOUT_EN
      to_cnt_reg    <= '0;
      res_err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (count_reg != '0 && !set_busy) begin
            state_reg   <= ISSUE;
            set_en      <= 1'b1;
            set_central <= head[23:0];
            set_radius  <= head[35:24];
            set_mode    <= head[37:36];
          end
        end
        ISSUE: begin
          set_en    <= 1'b0;
          state_reg <= WAIT;
`ifdef SET_SCHED_TIMEOUT_EN
          to_cnt_reg <= '0;
`endif
        end
        WAIT: begin
`ifdef SET_SCHED_TIMEOUT_EN
          to_cnt_reg <= to_cnt_reg + 10'd1;
`endif
          // set_valid takes priority over a coincident timeout.
          if (set_valid) begin
            res_candidate <= set_candidate;
            res_tag       <= head[41:38];
            res_valid     <= 1'b1;
            state_reg     <= OUT;
`ifdef SET_SCHED_TIMEOUT_EN
            res_err_reg   <= 1'b0;
`endif
          end else if (to_hit) begin
            res_candidate <= '0;
            res_tag       <= head[41:38];
            res_valid     <= 1'b1;
            state_reg     <= OUT;
`ifdef SET_SCHED_TIMEOUT_EN
            res_err_reg   <= 1'b1;
`endif
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_set_cmd_sched.sv
module tb_set_cmd_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [23:0] cmd_central;
  logic [11:0] cmd_radius;
  logic [1:0]  cmd_mode;
  logic        cmd_ready;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic        res_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  set_cmd_sched #(.FIFO_DEPTH(4), .TIMEOUT(1023)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_central(cmd_central), .cmd_radius(cmd_radius),
    .cmd_mode(cmd_mode), .cmd_ready(cmd_ready),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius),
    .set_mode(set_mode), .set_busy(set_busy), .set_valid(set_valid),
    .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
    .res_tag(res_tag), .res_err(res_err)
  );

  typedef struct {
    logic        cv;
    logic [23:0] cc;
    logic [11:0] cr;
    logic [1:0]  cm;
    logic        busy;
    logic        sv;
    logic [7:0]  sc;
    logic        rr;
    logic        e_ready;
    logic        e_en;
    logic        e_rv;
    logic [7:0]  e_cand;
    logic [3:0]  e_tag;
    logic [23:0] e_cent;
    logic [11:0] e_rad;
    logic [1:0]  e_mode;
  } vec_t;

  vec_t vecs [8];
  logic [23:0] bp_cent [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cmd_valid = 0; cmd_central = '0; cmd_radius = '0; cmd_mode = '0;
    set_busy = 0; set_valid = 0; set_candidate = '0; res_ready = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_set_en"}, set_en, 0);
    chk({tag, "_set_central"}, set_central, 0);
    chk({tag, "_set_radius"}, set_radius, 0);
    chk({tag, "_set_mode"}, set_mode, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_res_candidate"}, res_candidate, 0);
    chk({tag, "_res_tag"}, res_tag, 0);
    chk({tag, "_res_err"}, res_err, 0);
  endtask

  // Asynchronous reset asserted between clock edges; values checked before
  // any edge arrives, then released away from the active edge.
  task automatic do_reset(input string tag);
    clear_inputs();
    #2;
    rst = 1;
    #2;
    chk_reset_vals(tag);
    @(posedge clk);
    #1;
    rst = 0;
    $display("reset %s done", tag);
  endtask

  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    cmd_valid = 1; cmd_central = c; cmd_radius = r; cmd_mode = m;
    step();
    cmd_valid = 0;
  endtask

  task automatic wait_set_en(input string name);
    int n = 0;
    while (set_en !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    chk(name, set_en, 1);
  endtask

  // One full engine transaction: issue, hold, done strobe, result, consume.
  task automatic serve(input logic [3:0] etag, input logic [23:0] ecent, input logic [7:0] cand);
    wait_set_en("serve_set_en");
    chk("serve_central", set_central, ecent);
    repeat (3) step();
    chk("serve_en_pulse", set_en, 0);
    chk("serve_central_hold", set_central, ecent);
    set_valid = 1; set_candidate = cand;
    step();
    set_valid = 0;
    chk("serve_res_valid", res_valid, 1);
    chk("serve_res_tag", res_tag, etag);
    chk("serve_res_cand", res_candidate, cand);
    chk("serve_res_err", res_err, 0);
    res_ready = 1;
    step();
    res_ready = 0;
    chk("serve_res_clear", res_valid, 0);
    $display("serve tag=%0d central=%06h cand=%0d", res_tag, ecent, cand);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    //        cv cc          cr       cm busy sv sc     rr  rdy en rv cand  tag cent        rad      mode
    vecs[0] = '{1, 24'h335566, 12'h234, 2'd1, 0, 0, 8'd0,  0,  1, 0, 0, 8'd0,  0, 24'h0,      12'h0,   2'd0};
    vecs[1] = '{0, 24'h0,      12'h0,   2'd0, 0, 0, 8'd0,  0,  1, 1, 0, 8'd0,  0, 24'h335566, 12'h234, 2'd1};
    vecs[2] = '{0, 24'h0,      12'h0,   2'd0, 0, 0, 8'd0,  0,  1, 0, 0, 8'd0,  0, 24'h335566, 12'h234, 2'd1};
    vecs[3] = '{0, 24'h0,      12'h0,   2'd0, 0, 1, 8'd17, 0,  1, 0, 1, 8'd17, 0, 24'h335566, 12'h234, 2'd1};
    vecs[4] = '{0, 24'h0,      12'h0,   2'd0, 0, 0, 8'd0,  0,  1, 0, 1, 8'd17, 0, 24'h335566, 12'h234, 2'd1};
    vecs[5] = '{0, 24'h0,      12'h0,   2'd0, 0, 0, 8'd0,  1,  1, 0, 0, 8'd17, 0, 24'h335566, 12'h234, 2'd1};
    vecs[6] = '{0, 24'h0,      12'h0,   2'd0, 0, 1, 8'd99, 0,  1, 0, 0, 8'd17, 0, 24'h335566, 12'h234, 2'd1};
    vecs[7] = '{0, 24'h0,      12'h0,   2'd0, 0, 0, 8'd0,  0,  1, 0, 0, 8'd17, 0, 24'h335566, 12'h234, 2'd1};
    for (int i = 0; i < 5; i++) bp_cent[i] = {8'h10 + 8'(i), 8'hA0 + 8'(i), 8'h0F};

    // Power-on reset
    clear_inputs();
    rst = 1;
    #12;
    chk_reset_vals("por");
    @(posedge clk);
    #1;
    rst = 0;

    // Single command, cycle by cycle
    for (int i = 0; i < 8; i++) begin
      cmd_valid = vecs[i].cv; cmd_central = vecs[i].cc; cmd_radius = vecs[i].cr;
      cmd_mode = vecs[i].cm; set_busy = vecs[i].busy; set_valid = vecs[i].sv;
      set_candidate = vecs[i].sc; res_ready = vecs[i].rr;
      step();
      chk($sformatf("vec%0d_cmd_ready", i), cmd_ready, vecs[i].e_ready);
      chk($sformatf("vec%0d_set_en", i), set_en, vecs[i].e_en);
      chk($sformatf("vec%0d_res_valid", i), res_valid, vecs[i].e_rv);
      chk($sformatf("vec%0d_res_cand", i), res_candidate, vecs[i].e_cand);
      chk($sformatf("vec%0d_res_tag", i), res_tag, vecs[i].e_tag);
      chk($sformatf("vec%0d_res_err", i), res_err, 0);
      chk($sformatf("vec%0d_set_central", i), set_central, vecs[i].e_cent);
      chk($sformatf("vec%0d_set_radius", i), set_radius, vecs[i].e_rad);
      chk($sformatf("vec%0d_set_mode", i), set_mode, vecs[i].e_mode);
      $display("vec %0d: rdy=%0b en=%0b rv=%0b cand=%0d tag=%0d", i, cmd_ready, set_en,
               res_valid, res_candidate, res_tag);
    end
    clear_inputs();

    // Backpressure: engine stalls in WAIT while the FIFO fills
    do_reset("bp");
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1; cmd_central = bp_cent[i]; cmd_radius = 12'h111; cmd_mode = 2'd2;
      step();
      chk($sformatf("bp_ready_after_push%0d", i), cmd_ready, (i < 3) ? 1 : 0);
    end
    cmd_central = bp_cent[4];
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_ready_stalled%0d", i), cmd_ready, 0);
    end
    set_valid = 1; set_candidate = 8'hA0;
    step();
    set_valid = 0;
    chk("bp_ready_after_pop", cmd_ready, 1);
    chk("bp_res_valid0", res_valid, 1);
    chk("bp_res_tag0", res_tag, 0);
    chk("bp_res_cand0", res_candidate, 8'hA0);
    step();  // fifth command accepted on this edge
    cmd_valid = 0;
    chk("bp_ready_full_again", cmd_ready, 0);
    res_ready = 1;
    step();
    res_ready = 0;
    chk("bp_res_clear0", res_valid, 0);
    $display("serve tag=0 central=%06h cand=160", bp_cent[0]);
    for (int i = 1; i < 5; i++) serve(4'(i), bp_cent[i], 8'(8'h30 + i));

    // Busy gating
    do_reset("busy");
    set_busy = 1;
    push(24'hABCDEF, 12'h567, 2'd3);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("busy_no_en%0d", i), set_en, 0);
    end
    set_busy = 0;
    step();
    chk("busy_en_after_release", set_en, 1);
    chk("busy_central", set_central, 24'hABCDEF);
    set_busy = 1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("busy_hold_central%0d", i), set_central, 24'hABCDEF);
      chk($sformatf("busy_hold_radius%0d", i), set_radius, 12'h567);
      chk($sformatf("busy_hold_mode%0d", i), set_mode, 3);
    end
    set_valid = 1; set_candidate = 8'd42;
    step();
    set_valid = 0; set_busy = 0;
    chk("busy_res_valid", res_valid, 1);
    chk("busy_res_cand", res_candidate, 42);
    chk("busy_res_tag", res_tag, 0);
    res_ready = 1;
    step();
    res_ready = 0;
    $display("busy gating transaction tag=0 cand=42");

    // Result stall: second command must wait behind an unconsumed result
    push(24'h010203, 12'h321, 2'd0);
    push(24'h040506, 12'h654, 2'd1);
    wait_set_en("stall_set_en1");
    repeat (2) step();
    set_valid = 1; set_candidate = 8'd77;
    step();
    set_valid = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("stall_rv%0d", i), res_valid, 1);
      chk($sformatf("stall_tag%0d", i), res_tag, 1);
      chk($sformatf("stall_cand%0d", i), res_candidate, 77);
      chk($sformatf("stall_no_en%0d", i), set_en, 0);
    end
    res_ready = 1;
    step();
    res_ready = 0;
    chk("stall_release", res_valid, 0);
    step();
    chk("stall_next_issue", set_en, 1);
    $display("stall released, next command issued");
    serve(4'd2, 24'h040506, 8'd88);

    // Reset mid-WAIT with three commands still queued
    do_reset("pre_mid");
    for (int i = 0; i < 4; i++) push(bp_cent[i], 12'h999, 2'd2);
    chk("mid_in_wait_no_en", set_en, 0);
    chk("mid_ready_low", cmd_ready, 0);
    do_reset("mid_wait");
    repeat (3) begin
      step();
      chk("mid_no_en_after_reset", set_en, 0);
    end
    push(24'h778899, 12'hABC, 2'd1);
    serve(4'd0, 24'h778899, 8'd5);

`ifdef SET_SCHED_TIMEOUT_EN
    begin
      int n;
      do_reset("to");
      push(24'h111111, 12'h111, 2'd0);
      wait_set_en("to_set_en0");
      n = 0;
      while (res_valid !== 1'b1 && n < 1100) begin
        step();
        n++;
      end
      chk("to_latency", n, 1024);
      chk("to_res_err", res_err, 1);
      chk("to_res_cand", res_candidate, 0);
      chk("to_res_tag", res_tag, 0);
      res_ready = 1;
      step();
      res_ready = 0;
      $display("timeout transaction tag=0 err=1");
      push(24'h222222, 12'h222, 2'd1);
      wait_set_en("to_set_en1");
      repeat (1023) step();
      set_valid = 1; set_candidate = 8'd55;
      step();
      set_valid = 0;
      chk("to_race_valid", res_valid, 1);
      chk("to_race_err", res_err, 0);
      chk("to_race_cand", res_candidate, 55);
      chk("to_race_tag", res_tag, 1);
      res_ready = 1;
      step();
      res_ready = 0;
      $display("timeout race transaction tag=1 err=0");
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
